seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU for the adding-machine datapath. Supports
//   pass, add with carry-out, and unsigned restoring division with remainder.
//   Sits between the operand registers and the accumulator/output register.
//   Start/busy/done handshake lets the controller issue ops and wait for results.
// PARAMETERS
//   WIDTH     8   operand/result width in bits (>=2)
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   start      in   1      request; sampled only when busy==0
//   op         in   2      00 pass A, 01 add, 10 divide, 11 reserved (acts as pass)
//   a_side     in   WIDTH  operand A (dividend); captured on accepted start
//   b_side     in   WIDTH  operand B (divisor); captured on accepted start
//   abort      in   1      synchronous cancel of an in-flight divide
//   alu_out    out  WIDTH  result (sum / quotient / A)
//   remainder  out  WIDTH  divide remainder; 0 for pass/add
//   carry      out  1      add carry-out; 0 for other ops
//   div_zero   out  1      divide by zero detected on the last op
//   busy       out  1      divide in progress; start ignored while high
//   done       out  1      one-cycle pulse: outputs updated this cycle
// BEHAVIOUR
// - Reset (rst_n low, async): state IDLE, counter 0. alu_out, remainder,
//   carry, div_zero, busy, done all 0.
// - States: IDLE, DIV.
//   - IDLE, start=1 accepted at edge k:
//     - Pass, add, reserved, or divide with b==0: result registered at edge k.
//       done=1 for the cycle after edge k. State stays IDLE (latency 1).
//     - Divide with b!=0: operands latched, quotient/remainder regs cleared,
//       counter=WIDTH, busy=1, state -> DIV. No output regs change yet.
//   - DIV: one restoring step per edge, MSB first:
//     - rem = {rem, q[MSB]}
//     - if rem >= B: rem -= B, quotient bit = 1.
//     - After the WIDTH-th step (edge k+WIDTH): alu_out=quotient,
//       remainder=rem, carry=0, div_zero=0, busy=0, done=1 for one cycle,
//       state -> IDLE.
//     - Divide latency = WIDTH edges.
//   - The partial remainder needs WIDTH+1 bits internally.
// - Add: {carry, alu_out} = a_side + b_side, full WIDTH+1-bit sum.
//   Wrap-around is reported via carry. remainder=0, div_zero=0.
// - Pass: alu_out = a_side. carry=0, remainder=0, div_zero=0.
// - Divide by zero: alu_out=0, remainder=a_side, div_zero=1, carry=0,
//   latency 1.
// - Outputs hold their last value until the next completion. done is never
//   high two cycles in a row for the same op.
// - start while busy=1: ignored, no queuing, operands not recaptured.
// - Back-to-back ops:
//   - start may be high in the same cycle as done; it is accepted
//     (state is IDLE then).
//   - Consecutive 1-cycle ops give a done pulse every cycle.
// - abort=1 in DIV: return to IDLE next edge, busy=0, done=0, outputs keep
//   their previous values. abort in IDLE: no effect. abort has priority
//   over the final step.
// - Reset mid-divide: immediately IDLE, all outputs 0. No done is produced
//   for the lost op.
// TESTING
//   1. add 200+100 (W=8): alu_out=44, carry=1, done 1 cycle after start.
//   2. div 200/7: busy 8 cycles, then alu_out=28, remainder=4, done 1 pulse.
//   3. div 200/0: next cycle alu_out=0, remainder=200, div_zero=1, busy never set.
//   4. start add 1+1 during div busy: ignored; div result 255/16 -> 15 rem 15 intact.
//   5. rst_n low at step 4 of div: outputs 0 immediately; abort at step 3: no done.
//   6. W=16: 65535/1 -> 65535 rem 0 after 16 cycles; pass op 11 -> alu_out=A.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU for the adding-machine datapath.
// Single-cycle pass/add/div-by-zero; restoring divide one bit per clock.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_DIV  = 2'b10,
        OP_RSV  = 2'b11
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } alu_state_e;

endpackage

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_side,
    input  logic [WIDTH-1:0] b_side,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] remainder,
    output logic             carry,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_e       state_q;
    alu_state_e       state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;

    logic             accept;
    logic             div_go;
    logic             last_step;

    logic [WIDTH:0]   rem_sh;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    logic [WIDTH-1:0] res_y;
    logic [WIDTH-1:0] res_r;
    logic             res_c;
    logic             res_dz;

    assign accept    = start && (state_q == S_IDLE);
    assign div_go    = accept && (op == OP_DIV) && (b_side != '0);
    assign last_step = (cnt_q == CW'(1));
    assign busy      = (state_q == S_DIV);

    // Partial remainder is WIDTH+1 bits; after a subtract it fits WIDTH.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        q_bit   = rem_sh[WIDTH] || (rem_sh[WIDTH-1:0] >= dvs_q);
        rem_nxt = q_bit ? (rem_sh[WIDTH-1:0] - dvs_q)
                        : rem_sh[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        res_y  = '0;
        res_r  = '0;
        res_c  = 1'b0;
        res_dz = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                {res_c, res_y} = {1'b0, a_side} + {1'b0, b_side};
            end
            (op == OP_DIV): begin
                res_r  = a_side;
                res_dz = 1'b1;
            end
            default: begin
                res_y = a_side;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (div_go) begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (abort || last_step) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            alu_out   <= '0;
            remainder <= '0;
            carry     <= 1'b0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (div_go) begin
                        quo_q <= a_side;
                        dvs_q <= b_side;
                        rem_q <= '0;
                        cnt_q <= CW'(WIDTH);
                    end else if (accept) begin
                        alu_out   <= res_y;
                        remainder <= res_r;
                        carry     <= res_c;
                        div_zero  <= res_dz;
                        done      <= 1'b1;
                    end
                end
                S_DIV: begin
                    // Abort wins over the final step: no result, no done.
                    if (abort) begin
                        cnt_q <= '0;
                    end else begin
                        quo_q <= quo_nxt;
                        rem_q <= rem_nxt;
                        cnt_q <= cnt_q - CW'(1);
                        if (last_step) begin
                            alu_out   <= quo_nxt;
                            remainder <= rem_nxt;
                            carry     <= 1'b0;
                            div_zero  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule
